// File: rtl/tap_sequencer.sv
// TMS-driving initiator for a JTAG TAP: walks a shadow copy of the TAP state
// machine to a requested state along a shortest path, then optionally idles there.
module tap_sequencer #(
    parameter int HOLD_W = 8
) (
    input  logic              GCLK,
    input  logic              TRST,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [3:0]        cmd_target,
    input  logic [HOLD_W-1:0] cmd_hold,
    output logic              tms,
    output logic              tck_en,
    output logic [3:0]        cur_state,
    output logic              busy,
    output logic              done
);

    localparam logic [3:0] S_TLR = 4'hF;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WALK,
        ST_HOLD,
        ST_DONE
    } state_e;

    function automatic logic [3:0] tap_next(input logic [3:0] s, input logic b);
        logic [3:0] n;
        n = s;
        case (s)
            4'hF: n = b ? 4'hF : 4'hC;
            4'hC: n = b ? 4'h7 : 4'hC;
            4'h7: n = b ? 4'h4 : 4'h6;
            4'h6: n = b ? 4'h1 : 4'h2;
            4'h2: n = b ? 4'h1 : 4'h2;
            4'h1: n = b ? 4'h5 : 4'h3;
            4'h3: n = b ? 4'h0 : 4'h3;
            4'h0: n = b ? 4'h5 : 4'h2;
            4'h5: n = b ? 4'h7 : 4'hC;
            4'h4: n = b ? 4'hF : 4'hE;
            4'hE: n = b ? 4'h9 : 4'hA;
            4'hA: n = b ? 4'h9 : 4'hA;
            4'h9: n = b ? 4'hD : 4'hB;
            4'hB: n = b ? 4'h8 : 4'hB;
            4'h8: n = b ? 4'hD : 4'hA;
            4'hD: n = b ? 4'h7 : 4'hC;
        endcase
        return n;
    endfunction

    function automatic logic is_stable(input logic [3:0] s);
        return (s == 4'hF) || (s == 4'hC) || (s == 4'h2) ||
               (s == 4'h3) || (s == 4'hA) || (s == 4'hB);
    endfunction

    // Breadth-first reach count from src to dst over the 16-state graph.
    function automatic logic [4:0] path_len(input logic [3:0] src, input logic [3:0] dst);
        logic [15:0] reach;
        logic [15:0] grow;
        logic [4:0]  len;
        reach = 16'd1 << src;
        grow  = '0;
        len   = 5'd0;
        for (int i = 0; i < 16; i++) begin
            if (!reach[dst]) begin
                grow = reach;
                for (int j = 0; j < 16; j++) begin
                    if (reach[j]) begin
                        grow[tap_next(4'(j), 1'b0)] = 1'b1;
                        grow[tap_next(4'(j), 1'b1)] = 1'b1;
                    end
                end
                reach = grow;
                len   = len + 5'd1;
            end
        end
        return len;
    endfunction

    // First-edge TMS for every (current, target) pair, resolved at elaboration.
    // A 1 is chosen only when it is strictly shorter, so ties go to TMS=0.
    function automatic logic [255:0] build_hop();
        logic [255:0] t;
        t = '0;
        for (int c = 0; c < 16; c++) begin
            for (int g = 0; g < 16; g++) begin
                t[c*16+g] = path_len(tap_next(4'(c), 1'b1), 4'(g)) <
                            path_len(tap_next(4'(c), 1'b0), 4'(g));
            end
        end
        return t;
    endfunction

    localparam logic [255:0] HOP_TBL = build_hop();

    state_e            state_q, state_d;
    logic [3:0]        cur_q, cur_d;
    logic [3:0]        tgt_q, tgt_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic              tms_q, tms_d;
    logic              tck_en_q, tck_en_d;
    logic              ready_q, ready_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    always_comb begin
        state_d  = state_q;
        cur_d    = cur_q;
        tgt_d    = tgt_q;
        hold_d   = hold_q;
        tms_d    = tms_q;
        tck_en_d = 1'b0;
        ready_d  = ready_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (cmd_valid && ready_q) begin
                    tgt_d   = cmd_target;
                    hold_d  = is_stable(cmd_target) ? cmd_hold : '0;
                    ready_d = 1'b0;
                    busy_d  = 1'b1;
                    // Already there: HOLD with a zero count completes on the next edge.
                    state_d = (cmd_target == cur_q) ? ST_HOLD : ST_WALK;
                end
            end
            ST_WALK, ST_HOLD: begin
                if (state_q == ST_WALK && cur_q != tgt_q) begin
                    tms_d    = HOP_TBL[{cur_q, tgt_q}];
                    tck_en_d = 1'b1;
                    cur_d    = tap_next(cur_q, tms_d);
                end else if (hold_q != '0) begin
                    tms_d    = (tgt_q == S_TLR);
                    tck_en_d = 1'b1;
                    hold_d   = hold_q - HOLD_W'(1);
                    state_d  = ST_HOLD;
                end else begin
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                ready_d = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge GCLK or posedge TRST) begin
        if (TRST) begin
            state_q  <= ST_IDLE;
            cur_q    <= S_TLR;
            tgt_q    <= S_TLR;
            hold_q   <= '0;
            tms_q    <= 1'b1;
            tck_en_q <= 1'b0;
            ready_q  <= 1'b1;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cur_q    <= cur_d;
            tgt_q    <= tgt_d;
            hold_q   <= hold_d;
            tms_q    <= tms_d;
            tck_en_q <= tck_en_d;
            ready_q  <= ready_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign cmd_ready = ready_q;
    assign tms       = tms_q;
    assign tck_en    = tck_en_q;
    assign cur_state = cur_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_tap_sequencer.sv
// Directed plus randomized bench for tap_sequencer; expected TMS streams come from
// a brute-force shortest-sequence search over the TAP transition table.
module tb_tap_sequencer;
    localparam int HOLD_W = 8;

    logic              GCLK = 1'b0;
    logic              TRST;
    logic              cmd_valid;
    logic              cmd_ready;
    logic [3:0]        cmd_target;
    logic [HOLD_W-1:0] cmd_hold;
    logic              tms;
    logic              tck_en;
    logic [3:0]        cur_state;
    logic              busy;
    logic              done;

    tap_sequencer #(.HOLD_W(HOLD_W)) dut (
        .GCLK      (GCLK),
        .TRST      (TRST),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_target(cmd_target),
        .cmd_hold  (cmd_hold),
        .tms       (tms),
        .tck_en    (tck_en),
        .cur_state (cur_state),
        .busy      (busy),
        .done      (done)
    );

    always #5 GCLK = ~GCLK;

    int errors = 0;
    int checks = 0;
    int nx0[16];
    int nx1[16];
    int m_cur;
    int m_tms;
    bit exp_tms[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
        checks++;
        assert (obs === want) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, want);
        end
    endtask

    task automatic step();
        @(posedge GCLK);
        #1;
    endtask

    function automatic bit stable(input int s);
        return s == 15 || s == 12 || s == 2 || s == 3 || s == 10 || s == 11;
    endfunction

    // Lexicographically smallest TMS sequence of minimal length (0 before 1 at every edge).
    task automatic plan_path(input int from, input int to);
        exp_tms.delete();
        for (int n = 0; n <= 10; n++) begin
            for (int v = 0; v < (1 << n); v++) begin
                int s;
                s = from;
                for (int b = n - 1; b >= 0; b--) s = ((v >> b) & 1) != 0 ? nx1[s] : nx0[s];
                if (s == to) begin
                    for (int b = n - 1; b >= 0; b--) exp_tms.push_back(((v >> b) & 1) != 0);
                    return;
                end
            end
        end
    endtask

    task automatic run_cmd(input int tgt, input int hold, input bit noise);
        int h;
        int n;
        h = stable(tgt) ? hold : 0;
        plan_path(m_cur, tgt);
        n = exp_tms.size();
        for (int i = 0; i < h; i++) exp_tms.push_back(tgt == 15);
        chk("ready_before", 32'(cmd_ready), 1);
        cmd_valid  = 1'b1;
        cmd_target = 4'(tgt);
        cmd_hold   = HOLD_W'(hold);
        step();
        cmd_valid = 1'b0;
        chk("accept_ready", 32'(cmd_ready), 0);
        chk("accept_tck", 32'(tck_en), 0);
        chk("accept_busy", 32'(busy), 1);
        for (int i = 0; i < exp_tms.size(); i++) begin
            if (noise) begin
                cmd_valid  = 1'($urandom_range(0, 1));
                cmd_target = 4'($urandom_range(0, 15));
                cmd_hold   = HOLD_W'($urandom);
            end
            step();
            if (i < n) m_cur = exp_tms[i] ? nx1[m_cur] : nx0[m_cur];
            m_tms = int'(exp_tms[i]);
            chk("pulse_tck", 32'(tck_en), 1);
            chk("pulse_tms", 32'(tms), m_tms);
            chk("pulse_cur", 32'(cur_state), m_cur);
            chk("pulse_done", 32'(done), 0);
            chk("pulse_busy", 32'(busy), 1);
        end
        cmd_valid = 1'b0;
        step();
        chk("done_pulse", 32'(done), 1);
        chk("done_tck", 32'(tck_en), 0);
        chk("done_ready", 32'(cmd_ready), 0);
        chk("done_cur", 32'(cur_state), tgt);
        chk("done_tms", 32'(tms), m_tms);
        step();
        chk("idle_done", 32'(done), 0);
        chk("idle_ready", 32'(cmd_ready), 1);
        chk("idle_busy", 32'(busy), 0);
    endtask

    initial begin
        nx0 = '{2, 3, 2, 3, 14, 12, 2, 6, 10, 11, 10, 11, 12, 12, 10, 12};
        nx1 = '{5, 5, 1, 0, 15, 7, 1, 4, 13, 13, 9, 8, 7, 7, 9, 15};
        m_cur = 15;
        m_tms = 1;
        TRST = 1'b1;
        cmd_valid = 1'b0;
        cmd_target = 4'h0;
        cmd_hold = '0;
        #2;
        chk("rst_tms", 32'(tms), 1);
        chk("rst_tck", 32'(tck_en), 0);
        chk("rst_cur", 32'(cur_state), 15);
        chk("rst_ready", 32'(cmd_ready), 1);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);

        // A command presented while reset is held must not be taken.
        cmd_valid = 1'b1;
        cmd_target = 4'h2;
        step();
        TRST = 1'b0;
        cmd_valid = 1'b0;
        step();
        chk("rstcmd_ready", 32'(cmd_ready), 1);
        chk("rstcmd_tck", 32'(tck_en), 0);
        step();
        chk("rstcmd_cur", 32'(cur_state), 15);

        run_cmd(2, 0, 0);
        run_cmd(3, 3, 0);
        run_cmd(12, 0, 0);
        run_cmd(10, 0, 0);
        run_cmd(15, 0, 0);
        run_cmd(15, 0, 0);
        run_cmd(1, 5, 0);
        run_cmd(12, 255, 0);
        run_cmd(15, 0, 0);

        // Reset after the third pulse of a walk toward ShDR.
        cmd_valid = 1'b1;
        cmd_target = 4'h2;
        cmd_hold = '0;
        step();
        cmd_valid = 1'b0;
        repeat (3) begin
            step();
            chk("pre_rst_tck", 32'(tck_en), 1);
        end
        TRST = 1'b1;
        #1;
        chk("arst_tck", 32'(tck_en), 0);
        chk("arst_tms", 32'(tms), 1);
        chk("arst_cur", 32'(cur_state), 15);
        chk("arst_ready", 32'(cmd_ready), 1);
        chk("arst_busy", 32'(busy), 0);
        step();
        TRST = 1'b0;
        m_cur = 15;
        m_tms = 1;
        repeat (4) begin
            step();
            chk("post_rst_done", 32'(done), 0);
            chk("post_rst_tck", 32'(tck_en), 0);
        end

        run_cmd(2, 2, 1);
        run_cmd(10, 1, 1);

        for (int k = 0; k < 40; k++) begin
            int g;
            run_cmd(int'($urandom_range(0, 15)), int'($urandom_range(0, 6)), 1'($urandom_range(0, 1)));
            g = int'($urandom_range(0, 3));
            for (int j = 0; j < g; j++) begin
                step();
                chk("gap_tck", 32'(tck_en), 0);
                chk("gap_done", 32'(done), 0);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/tap_sequencer.md
# tap_sequencer

TMS-driving initiator for the TAP controller, on the master side of the TAP interface. It accepts a target TAP state and an optional hold count. It walks the TAP along the shortest path by issuing TMS bits, each qualified by a per-cycle TCK enable. It keeps a shadow copy of the TAP state machine so the controller always knows where the TAP will be.

## Interface
- HOLD_W, 8, width of the hold-cycle count.
- GCLK  in  1  system clock; all state updates on the rising edge.
- TRST  in  1  asynchronous, active-high reset. Shared with the TAP, so both sides reset together.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  command can be accepted this cycle.
- cmd_target  in  4  target TAP state code.
- cmd_hold  in  HOLD_W  extra self-loop clocks to apply once the target is reached.
- tms  out  1  registered TMS bit for the TAP.
- tck_en  out  1  registered; when 1, the TAP is clocked at the next GCLK edge and samples tms.
- cur_state  out  4  shadow state: the TAP state after every pulse already issued.
- busy  out  1  command in progress.
- done  out  1  one-cycle completion pulse.

## Operation
- State codes:
  - TLR 0xF, RTI 0xC
  - SelDR 0x7, CapDR 0x6, ShDR 0x2, Ex1DR 0x1, PauDR 0x3, Ex2DR 0x0, UpdDR 0x5
  - SelIR 0x4, CapIR 0xE, ShIR 0xA, Ex1IR 0x9, PauIR 0xB, Ex2IR 0x8, UpdIR 0xD
  - All 16 codes are valid targets.
- Shadow TAP next-state function is IEEE 1149.1 exact.
- Hop function hop(cur, tgt) returns the TMS bit on the first edge of a shortest path from cur to tgt. If two shortest paths exist, choose TMS=0.
- Stable states: TLR, RTI, ShDR, PauDR, ShIR, PauIR. Their self-loop TMS is 1 for TLR and 0 for the others.
- FSM states: IDLE, WALK, HOLD, DONE.
  - IDLE: cmd_ready=1, busy=0.
    - On valid&ready, latch the target and the hold count.
    - If cmd_target is not stable, the hold count is forced to 0.
    - If target==cur_state and hold==0, go to DONE; no pulses are issued.
    - Else if target==cur_state, go to HOLD.
    - Else go to WALK.
  - WALK: each edge registers tms=hop(cur,tgt) and tck_en=1, and sets cur_state to next(cur,tms). When the new cur_state equals the target, go to HOLD if hold>0, else DONE.
  - HOLD: each edge registers tms=self-loop bit and tck_en=1, and decrements the count; cur_state is unchanged. When the count reaches 0, go to DONE.
  - DONE: done=1 and cmd_ready=0 for exactly one cycle, then IDLE.
- Outside WALK/HOLD, tck_en=0 and tms holds its last value, so the TAP is not clocked.
- cmd_valid while cmd_ready=0 is ignored; there is no queuing.
- Reset values: state IDLE, cur_state=0xF, tms=1, tck_en=0, cmd_ready=1, busy=0, done=0.

## Timing
- Command accepted at edge k, with path length L hops and hold count H:
  - tck_en=1 for edges k+1 .. k+L+H.
  - cur_state advances at each of edges k+1 .. k+L.
  - done=1 in the cycle after edge k+L+H+1.
  - cmd_ready=1 again after edge k+L+H+2.
- The TAP samples tms one edge after it is registered, so the real TAP state equals cur_state one cycle later.
- Zero-length command (target==cur_state, H=0): done is asserted after edge k+1.
- TRST asserted mid-WALK or mid-HOLD: all outputs go to their reset values immediately (asynchronously). The command is dropped and no done pulse is produced.
- TRST deasserted and cmd_valid both present on the same edge: the command is not accepted on that edge.
- Hold counter is HOLD_W bits and never wraps below 0. The maximum hold is 2^HOLD_W-1 clocks.

## Test plan
- Reset, then target ShDR (0x2) with hold 0 -> tms 0,1,0,0 on four tck_en cycles; cur_state goes C,7,6,2; done pulses once.
- From ShDR, target PauDR (0x3) with hold 3 -> tms 1,0 then 0,0,0; tck_en=1 for 5 cycles; cur_state ends at 0x3.
- From RTI, target ShIR (0xA) -> tms 1,1,0,0. Then target TLR (0xF) -> tms 1,1,1,1,1 and cur_state ends at 0xF.
- Target equal to current (TLR, hold 0) -> no tck_en pulse; done is asserted one cycle after accept. Target Ex1DR with hold 5 -> hold ignored, no extra pulses.
- Assert TRST at the third pulse of a ShDR walk -> tck_en=0, tms=1, cur_state=0xF, cmd_ready=1 immediately; no done pulse.
- Pulse cmd_valid during busy with a different target -> ignored; the original walk completes unchanged.
